// File: rtl/rv32i_fetch_pkg.sv
// Shared constants and types for the RV32I fetch front end.
// Imported by fetch_fifo and rv32i_fetch_queue.
package rv32i_fetch_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int INSTR_W      = 32;
  localparam int PC_STEP      = 4;

  typedef struct packed {
    logic [INSTR_W-1:0]      instr;
    logic [XLEN_DEFAULT-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count.
// Used for the instruction queue and the request-PC order FIFO.
module fetch_fifo
  import rv32i_fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && (cnt_q != CW'(DEPTH));
  assign pop_ok  = pop_i && (cnt_q != '0);
  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;

  // Pointer and count next state; flush discards everything.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + AW'(1);
      if (pop_ok)  rptr_d = rptr_q + AW'(1);
      cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/rv32i_fetch_queue.sv
// Latency-tolerant multi-outstanding instruction fetch front end.
// Optional macro FETCH_MISALIGN_CHK_EN: flag and halt on misaligned redirect.
module rv32i_fetch_queue
  import rv32i_fetch_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEFAULT,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            misalign_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = INSTR_W + XLEN;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   occ, inflight;
  logic [CW:0]     used;
  logic            credit, halted, req_fire;
  logic            q_push, q_pop;
  logic [XLEN-1:0] rsp_pc, tgt;
  logic [EW-1:0]   q_rdata;

`ifdef FETCH_MISALIGN_CHK_EN
  logic halt_q, halt_d;
  logic misal;

  assign misal        = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign tgt          = redirect_pc;
  assign halted       = halt_q;
  assign misalign_err = halt_q;
  assign halt_d       = halt_q | misal;

  // Sticky misalignment flag, which also halts fetch until reset.
  always_ff @(posedge clk) begin
    if (rst) halt_q <= 1'b0;
    else     halt_q <= halt_d;
  end
`else
  assign tgt          = redirect_pc & ~XLEN'(3);
  assign halted       = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Outstanding requests plus queued words may never exceed the queue.
  assign used   = {1'b0, occ} + {1'b0, inflight};
  assign credit = used < (CW+1)'(DEPTH);

  assign imem_req_valid = !rst && !redirect_valid && credit && !halted;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign q_push = imem_rsp_valid && !redirect_valid && (discard_q == '0);
  assign q_pop  = instr_valid && instr_ready;

  assign instr_valid = occ != '0;
  assign instr       = q_rdata[EW-1:XLEN];
  assign instr_pc    = q_rdata[XLEN-1:0];

  // PC of every accepted request, popped as its response returns.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_order (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (1'b0),
    .push_i  (req_fire),
    .wdata_i (pc_q),
    .pop_i   (imem_rsp_valid),
    .rdata_o (rsp_pc),
    .count_o (inflight)
  );

  // Instruction queue; a redirect flushes it after any pop completes.
  fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_queue (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (redirect_valid),
    .push_i  (q_push),
    .wdata_i ({imem_rsp_data, rsp_pc}),
    .pop_i   (q_pop),
    .rdata_o (q_rdata),
    .count_o (occ)
  );

  // Next PC and count of stale responses still to be dropped.
  always_comb begin
    pc_d      = pc_q;
    discard_d = discard_q;
    if (redirect_valid) begin
      pc_d      = tgt;
      discard_d = inflight - CW'(imem_rsp_valid);
    end else begin
      if (req_fire)
        pc_d = pc_q + XLEN'(PC_STEP);
      if (imem_rsp_valid && discard_q != '0)
        discard_d = discard_q - CW'(1);
    end
  end

  // PC and discard registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      discard_q <= '0;
    end else begin
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

endmodule

// File: tb/tb_rv32i_fetch_queue.sv
// Randomized self-checking bench for rv32i_fetch_queue.
// Reference: delivered PCs run sequentially from the last redirect target.
module tb_rv32i_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign_err;

  rv32i_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] got[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          rdy_pct, dec_pct, lat_min, lat_max;
  int          req_cnt, deliv_cnt;
  logic [31:0] exp_pc, exp_req;
  logic        o_rv, o_iv, o_rsp, o_mis;
  logic [31:0] o_ra, o_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHK_EN
    return t;
`else
    return t & ~32'h3;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    instr_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 ||
        misalign_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state req_valid=%b instr_valid=%b mis=%b want 0 0 0",
               imem_req_valid, instr_valid, misalign_err);
    end
    pend.delete();
    got.delete();
    last_due = cyc;
    exp_pc = RPC;
    exp_req = RPC;
    req_cnt = 0;
    deliv_cnt = 0;
  endtask

  // One clock: drive inputs, check against the model, advance the model.
  task automatic cycle(input logic rv, input logic [31:0] rt);
    int lat, due;
    @(negedge clk);
    rst = 1'b0;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    instr_ready = ($urandom_range(99) < dec_pct);
    redirect_valid = rv;
    redirect_pc = rt;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = mem_word(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data = $urandom;
    end
    #1;
    o_rv = imem_req_valid; o_ra = imem_req_addr;
    o_iv = instr_valid; o_pc = instr_pc;
    o_rsp = imem_rsp_valid; o_mis = misalign_err;
    checks++;
    if (pend.size() > DEPTH) begin
      failures++;
      $display("FAIL outstanding=%0d limit=%0d", pend.size(), DEPTH);
    end
    if (rv) begin
      checks++;
      if (imem_req_valid !== 1'b0) begin
        failures++;
        $display("FAIL req_on_redirect req_valid=%b want 0", imem_req_valid);
      end
    end else if (imem_req_valid) begin
      checks++;
      if (imem_req_addr !== exp_req) begin
        failures++;
        $display("FAIL req_addr got=%h want=%h", imem_req_addr, exp_req);
      end
    end
    if (instr_valid) begin
      checks++;
      if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
        failures++;
        $display("FAIL instr pc=%h instr=%h want pc=%h instr=%h",
                 instr_pc, instr, exp_pc, mem_word(exp_pc));
      end
    end
    if (imem_rsp_valid) void'(pend.pop_front());
    if (instr_valid && instr_ready) begin
      got.push_back(instr_pc);
      exp_pc = exp_pc + 32'd4;
      deliv_cnt++;
    end
    if (imem_req_valid && imem_req_ready) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{addr: imem_req_addr, due: due});
      exp_req = exp_req + 32'd4;
      req_cnt++;
    end
    if (rv) begin
      exp_pc = align(rt);
      exp_req = align(rt);
      got.delete();
    end
    cyc++;
  endtask

  task automatic test_reset();
    rdy_pct = 100; dec_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    cycle(1'b0, '0);
    checks++;
    if (o_rv !== 1'b1 || o_ra !== RPC) begin
      failures++;
      $display("FAIL first_req valid=%b addr=%h want 1 %h", o_rv, o_ra, RPC);
    end
  endtask

  task automatic test_stream();
    int first_iv, d0;
    rdy_pct = 100; dec_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    first_iv = -1;
    d0 = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) d0 = deliv_cnt;
      cycle(1'b0, '0);
      if (o_iv && first_iv < 0) first_iv = i;
    end
    checks++;
    if (first_iv != 2) begin
      failures++;
      $display("FAIL first_instr_valid cycle=%0d want 2", first_iv);
    end
    checks++;
    if (deliv_cnt - d0 != 20) begin
      failures++;
      $display("FAIL throughput got=%0d want 20", deliv_cnt - d0);
    end
  endtask

  task automatic test_backpressure();
    int d0;
    rdy_pct = 100; dec_pct = 0; lat_min = 1; lat_max = 1;
    do_reset();
    repeat (12) cycle(1'b0, '0);
    checks++;
    if (req_cnt != DEPTH || o_rv !== 1'b0) begin
      failures++;
      $display("FAIL stall_reqs count=%0d valid=%b want %0d 0",
               req_cnt, o_rv, DEPTH);
    end
    checks++;
    if (o_iv !== 1'b1 || o_pc !== RPC) begin
      failures++;
      $display("FAIL stall_head valid=%b pc=%h want 1 %h", o_iv, o_pc, RPC);
    end
    dec_pct = 100;
    d0 = deliv_cnt;
    repeat (10) cycle(1'b0, '0);
    checks++;
    if (deliv_cnt - d0 < 8) begin
      failures++;
      $display("FAIL resume delivered=%0d want >=8", deliv_cnt - d0);
    end
  endtask

  task automatic test_redirect_stale();
    rdy_pct = 100; dec_pct = 0; lat_min = 3; lat_max = 3;
    do_reset();
    repeat (2) cycle(1'b0, '0);
    cycle(1'b1, 32'h100);
    dec_pct = 100;
    cycle(1'b0, '0);
    checks++;
    if (o_iv !== 1'b0 || o_rv !== 1'b1 || o_ra !== 32'h100) begin
      failures++;
      $display("FAIL redir_next iv=%b req=%b addr=%h want 0 1 100",
               o_iv, o_rv, o_ra);
    end
    repeat (12) cycle(1'b0, '0);
    checks++;
    if (got.size() == 0 || got[0] !== 32'h100) begin
      failures++;
      $display("FAIL redir_first_pc n=%0d pc=%h want 100",
               got.size(), got.size() ? got[0] : 32'hx);
    end
  endtask

  task automatic test_redirect_collide();
    logic iv_at, rsp_at;
    rdy_pct = 100; dec_pct = 100; lat_min = 2; lat_max = 2;
    do_reset();
    repeat (10) cycle(1'b0, '0);
    cycle(1'b1, 32'h200);
    iv_at = o_iv;
    rsp_at = o_rsp;
    checks++;
    if (iv_at !== 1'b1 || rsp_at !== 1'b1) begin
      failures++;
      $display("FAIL collide_setup iv=%b rsp=%b want 1 1", iv_at, rsp_at);
    end
    repeat (12) cycle(1'b0, '0);
    checks++;
    if (got.size() < 4 || got[0] !== 32'h200) begin
      failures++;
      $display("FAIL collide_resume n=%0d want >=4 from 200", got.size());
    end
  endtask

  task automatic test_misalign();
    int reqs;
    rdy_pct = 100; dec_pct = 100; lat_min = 2; lat_max = 2;
    do_reset();
    repeat (5) cycle(1'b0, '0);
    cycle(1'b1, 32'h102);
    cycle(1'b0, '0);
`ifdef FETCH_MISALIGN_CHK_EN
    checks++;
    if (o_mis !== 1'b1 || o_rv !== 1'b0) begin
      failures++;
      $display("FAIL misalign err=%b req=%b want 1 0", o_mis, o_rv);
    end
    reqs = 0;
    repeat (8) begin
      cycle(1'b0, '0);
      if (o_rv) reqs++;
    end
    checks++;
    if (reqs != 0 || o_mis !== 1'b1) begin
      failures++;
      $display("FAIL halt reqs=%0d err=%b want 0 1", reqs, o_mis);
    end
`else
    checks++;
    if (o_mis !== 1'b0 || o_rv !== 1'b1 || o_ra !== 32'h100) begin
      failures++;
      $display("FAIL misalign_off err=%b req=%b addr=%h want 0 1 100",
               o_mis, o_rv, o_ra);
    end
    reqs = 0;
    repeat (8) begin
      cycle(1'b0, '0);
      if (o_iv) reqs++;
    end
    checks++;
    if (reqs == 0) begin
      failures++;
      $display("FAIL misalign_off_fetch delivered=0 want >0");
    end
`endif
  endtask

  task automatic test_random();
    logic        rv;
    logic [31:0] rt;
    rdy_pct = 70; dec_pct = 60; lat_min = 1; lat_max = 4;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      rv = ($urandom_range(99) < 3);
      rt = $urandom & 32'h0000_fffc;
      cycle(rv, rt);
    end
    checks++;
    if (deliv_cnt < 100) begin
      failures++;
      $display("FAIL random_progress delivered=%0d want >=100", deliv_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_stale();
    test_redirect_collide();
    test_misalign();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
